pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised, handshaked pipeline stage register; successor to the fixed 2×32-bit IF/ID stall/flush register.
- Carries an arbitrary-width payload (e.g. {PCPlus4, Instr}) between any two pipeline stages.
- Uses valid/ready flow control with a 1-entry skid slot, so back-pressure never needs a combinational ready path.
- Flush inserts a bubble (NOP payload); instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 64, payload width in bits.
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data whenever the stage holds no valid entry.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers in_data.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  stage can accept; registered (function of state only).
- out_valid  output  1  out_data holds a valid entry.
- out_data  output  DATA_W  downstream payload.
- out_ready  input  1  downstream consumes this cycle.
- flush  input  1  synchronous kill of all held and incoming entries.
- stall_cnt  output  CNT_W  cycles with out_valid && !out_ready (optional feature).
- flush_cnt  output  CNT_W  cycles with flush asserted (optional feature).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst.
- State:
  - main slot: out_valid / out_data.
  - skid slot: skid_valid / skid_data.
- Reset values: out_valid=0, out_data=NOP_VALUE, skid_valid=0, skid_data=NOP_VALUE, in_ready=1, counters=0.
- Handshake signals:
  - in_ready = !skid_valid. It never depends on out_ready in the same cycle.
  - acc = in_valid && in_ready.
  - dlv = out_valid && out_ready.
- Priority per edge: rst > flush > normal update.
- Flush:
  - out_valid<=0, skid_valid<=0, out_data<=NOP_VALUE.
  - An entry offered the same cycle is dropped, even if in_ready=1. Upstream sees the handshake complete and must not resend.
  - A dlv occurring the same cycle still counts as consumed by downstream.
- Normal update:
  - Main empty or dlv:
    - If skid_valid: main<=skid, skid_valid<=0. If acc in the same cycle, the new entry goes to skid (skid_valid stays 1).
    - Else if acc: main<=in_data, out_valid<=1.
    - Else: out_valid<=0, out_data<=NOP_VALUE.
  - Main full and no dlv:
    - If acc: skid<=in_data, skid_valid<=1.
    - Main holds its value.
- Entry states (out_valid, skid_valid): EMPTY(0,0), ONE(1,0), TWO(1,1). State (0,1) is unreachable; assertion required.
- Latency and throughput:
  - Latency in→out is 1 cycle.
  - Sustains 1 entry/cycle with out_ready=1.
  - After out_ready deasserts, at most one further entry is accepted.
- Ordering: strict FIFO order. The skid entry is always older than any new input.
- Stability: out_data is stable while out_valid && !out_ready.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle out_valid && !out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at all-ones and are cleared by rst only.
- Undefined: stall_cnt and flush_cnt are tied to 0, with no counter flops.
- The ports exist in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTR (32'h0000_0000).
  - IFID_W=64, IDEX_W, EXMEM_W, MEMWB_W.
  - Stage payload typedef widths.
- One natural sub-module: pipe_sat_cnt (saturating CNT_W counter with enable and synchronous clear), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- rst=1 for 2 cycles, then idle → out_valid=0, out_data=0, in_ready=1, counters=0.
- Stream 0x1..0x8 with out_ready=1 every cycle → out_data 0x1..0x8 on consecutive cycles, each exactly 1 cycle after acceptance.
- Load 0xA, 0xB with out_ready=0 → state TWO, in_ready=0, 0xC held upstream; raise out_ready → outputs A, B, C in order with no loss or duplication.
- In state TWO (A, B held), assert flush with in_valid=1, in_data=0xD → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1; 0xD never appears.
- Simultaneous rst=1 and flush=1 mid-stream, DATA_W=96, NOP_VALUE=96'h13 → all state at reset values and out_data=96'h13.
- PIPE_STAGE_PERF_EN with CNT_W=3: hold out_valid && !out_ready for 10 cycles and pulse flush 2× → stall_cnt=7 (saturated), flush_cnt=2. Without the macro → both 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload layouts, their widths and the NOP instruction.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } exmem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic [1:0]  ctrl;
    } memwb_t;

    localparam int IFID_W  = $bits(ifid_t);
    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);

    localparam ifid_t IFID_NOP = '{pc_plus4: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module pipe_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with a 1-entry skid slot and flush-to-NOP.
// Optional stall/flush performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = IFID_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              acc, dlv;

    // Ready comes straight from the skid flop, so back-pressure never forms a combinational path.
    assign in_ready = !skid_valid_q;
    assign acc      = in_valid && in_ready;
    assign dlv      = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = NOP_VALUE;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || dlv) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = acc;
                if (acc) begin
                    skid_data_d = in_data;
                end
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = NOP_VALUE;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= NOP_VALUE;
            skid_valid_q <= 1'b0;
            // NOTE: payload flops are reset too, because out_data must read NOP_VALUE straight after reset.
            skid_data_q  <= NOP_VALUE;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    a_no_lone_skid: assert property (@(posedge clk) disable iff (rst) out_valid_q || !skid_valid_q);

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .en_i  (out_valid_q && !out_ready),
        .cnt_o (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .en_i  (flush),
        .cnt_o (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
